axis_stream_exerciser: RTL and testbench
========================================

Name: axis_stream_exerciser

Overview:
- Traffic source and checker for the opposite end of the team's AXI4-Stream processing IPs.
- On a start pulse it streams one packet of C_TX_WORDS incrementing words out of M_AXIS into the DUT's sink.
- It then accepts the DUT's reply packet on S_AXIS and compares it word-by-word against the sent pattern (loopback expectation).
- Results are reported as status flags, an error count and LEDs. Used for bring-up on the Zynq board and as a simulation driver.

Parameters:
C_M_AXIS_TDATA_WIDTH, 32, width of transmitted TDATA (multiple of 8)
C_S_AXIS_TDATA_WIDTH, 32, width of received TDATA; must equal C_M_AXIS_TDATA_WIDTH
C_TX_WORDS, 8, words per transmitted packet (>=1)
C_RX_WORDS, 8, expected words per reply packet (>=1, <=C_TX_WORDS)
C_START_COUNT, 32, idle cycles between start and first TVALID (>=1)
C_TIMEOUT, 1024, cycles without a handshake before abort (>=2)

Ports:
AXIS_ACLK  in  1  single clock for both stream interfaces
AXIS_ARESETN  in  1  reset, asynchronous assert, active low
start  in  1  one-cycle pulse, begins a test run; ignored while busy
seed  in  C_M_AXIS_TDATA_WIDTH  first data word, sampled on accepted start
M_AXIS_TVALID  out  1  transmit valid
M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  transmit data
M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  all ones
M_AXIS_TLAST  out  1  high on the final transmitted word
M_AXIS_TREADY  in  1  sink ready
S_AXIS_TREADY  out  1  checker ready
S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  reply data
S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  ignored
S_AXIS_TLAST  in  1  reply packet boundary
S_AXIS_TVALID  in  1  reply valid
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  last run clean (no mismatch, length or timeout error)
err_count  out  8  mismatched words in last run, saturating at 255
err_len  out  1  reply length error in last run
err_timeout  out  1  last run aborted on timeout
led  out  4  {busy, err_timeout, err_len|(err_count!=0), pass}

Behaviour:
- Reset (async, active low): FSM=IDLE; TVALID, TLAST, S_AXIS_TREADY, busy, done, pass, err_*, err_count, led all 0; TDATA 0. Asserting reset mid-run drops TVALID/TREADY immediately; no partial state survives.
- FSM states:
  - IDLE: start=1 -> latch seed, clear err_*/err_count/pass, busy=1 -> WAIT.
  - WAIT: count C_START_COUNT cycles -> SEND.
  - SEND: TVALID=1, TDATA=seed+idx (modulo 2^width, wraps), TLAST=(idx==C_TX_WORDS-1). On TVALID&TREADY, idx++. Handshake on the last word -> RECV (idx cleared).
  - RECV: S_AXIS_TREADY=1. On each handshake, compare TDATA to seed+idx; a mismatch increments err_count (saturating). Packet ends at the first of: TLAST, or the C_RX_WORDS-th word.
    - err_len=1 if TLAST arrives with idx!=C_RX_WORDS-1, or if word C_RX_WORDS-1 arrives without TLAST.
    - End -> REPORT.
  - REPORT: one cycle. done=1; pass=!(err_len|err_timeout|err_count!=0); busy=0 -> IDLE.
- TVALID and TDATA are driven from registers. Once TVALID is asserted, TDATA/TLAST stay stable until the handshake.
- First TVALID appears exactly C_START_COUNT+1 cycles after the cycle start is sampled. With TREADY held high, one word transfers per cycle.
- S_AXIS_TREADY is 0 outside RECV. Reply words arriving earlier are back-pressured, never dropped.
- Timeout: a cycle counter clears on every handshake and on state entry; it counts only in SEND and RECV. Reaching C_TIMEOUT -> err_timeout=1, TVALID/TREADY drop the next cycle, then REPORT.
- start during busy: no effect. start and reset together: reset wins.
- pass, err_*, err_count and led hold their value until the next accepted start.

Optional Feature:
AXIS_EXERCISER_BACKPRESSURE_EN
- Defined: in RECV, S_AXIS_TREADY is gated by a free-running toggle flop, so it is high only on alternate cycles. This exercises the DUT master's hold-while-not-ready logic. Timeout still counts per handshake.
- Undefined: S_AXIS_TREADY is held continuously high in RECV; the toggle logic is absent.

Test Plan:
- Ideal loopback: seed=0x00000010, sink always ready, reply echoes 0x10..0x17 with TLAST on the 8th word -> TVALID first high 33 cycles after start; 8 consecutive beats; done pulse; pass=1, err_count=0, led=4'b0001.
- Corrupted reply: reply word 3 = 0xDEADBEEF, others correct -> err_count=1, pass=0, err_len=0, led[1]=1.
- Early TLAST: reply has TLAST on word 5 of 8 -> err_len=1, pass=0; FSM in IDLE the cycle after done.
- Wrap and stall: seed=0xFFFFFFFE, TREADY low for 3 cycles at word 1 -> TDATA/TLAST held stable through the stall; sent sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, ...; pass=1.
- Timeout and reset: sink never ready, C_TIMEOUT=16 -> err_timeout=1, done pulse. In a second run, assert reset mid-SEND -> TVALID=0 in the same cycle, all status 0. A start pulse while busy is ignored.
- With AXIS_EXERCISER_BACKPRESSURE_EN defined: ideal loopback -> S_AXIS_TREADY alternates 1/0 in RECV; 8 words still accepted; pass=1.

Source files
------------

// File: rtl/axis_stream_exerciser.sv
// axis_stream_exerciser: on a start pulse, streams one packet of incrementing
// words out of M_AXIS, then checks the looped-back reply on S_AXIS word by word
// and reports pass / error flags / error count / LEDs.
// Optional build macro: AXIS_EXERCISER_BACKPRESSURE_EN -- when defined,
// S_AXIS_TREADY in RECV is high only on alternate cycles.
module axis_stream_exerciser #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_TX_WORDS           = 8,
  parameter int C_RX_WORDS           = 8,
  parameter int C_START_COUNT        = 32,
  parameter int C_TIMEOUT            = 1024
) (
  input  logic                              AXIS_ACLK,
  input  logic                              AXIS_ARESETN,
  input  logic                              start,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   seed,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic                              S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [7:0]                        err_count,
  output logic                              err_len,
  output logic                              err_timeout,
  output logic [3:0]                        led
);

  localparam int W      = C_M_AXIS_TDATA_WIDTH;
  localparam int IDX_W  = $clog2(C_TX_WORDS + 1);
  localparam int WAIT_W = $clog2(C_START_COUNT + 1);
  localparam int TO_W   = $clog2(C_TIMEOUT + 1);

  localparam logic [IDX_W-1:0]  TX_LAST_IDX = IDX_W'(C_TX_WORDS - 1);
  localparam logic [IDX_W-1:0]  RX_LAST_IDX = IDX_W'(C_RX_WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_END    = WAIT_W'(C_START_COUNT);
  localparam logic [TO_W-1:0]   TO_END      = TO_W'(C_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SEND,
    ST_RECV,
    ST_REPORT
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      seed_q, seed_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              tvalid_q, tvalid_d;
  logic [W-1:0]      tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              err_len_q, err_len_d;
  logic              err_timeout_q, err_timeout_d;
  logic              pass_q, pass_d;

  logic              s_tready;
  logic              tx_hs;
  logic              rx_hs;
  logic              rx_last_idx;
  logic [W-1:0]      rx_expect;
  logic              unused_tstrb;

  // Reply strobes carry no information for a loopback compare.
  assign unused_tstrb = ^S_AXIS_TSTRB;

`ifdef AXIS_EXERCISER_BACKPRESSURE_EN
  logic toggle_q;

  // Free-running phase flop: lets the checker accept only every other cycle.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) toggle_q <= 1'b0;
    else               toggle_q <= ~toggle_q;
  end

  assign s_tready = (state_q == ST_RECV) & toggle_q;
`else
  assign s_tready = (state_q == ST_RECV);
`endif

  assign tx_hs       = tvalid_q & M_AXIS_TREADY;
  assign rx_hs       = S_AXIS_TVALID & s_tready;
  assign rx_last_idx = (idx_q == RX_LAST_IDX);
  assign rx_expect   = seed_q + W'(idx_q);

  // Next-state logic for the run sequencer, counters and status.
  always_comb begin
    state_d       = state_q;
    seed_d        = seed_q;
    idx_d         = idx_q;
    wait_d        = wait_q;
    to_d          = to_q;
    tvalid_d      = tvalid_q;
    tdata_d       = tdata_q;
    tlast_d       = tlast_q;
    err_count_d   = err_count_q;
    err_len_d     = err_len_q;
    err_timeout_d = err_timeout_q;
    pass_d        = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          seed_d        = seed;
          err_count_d   = '0;
          err_len_d     = 1'b0;
          err_timeout_d = 1'b0;
          pass_d        = 1'b0;
          wait_d        = '0;
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_END) begin
          state_d  = ST_SEND;
          tvalid_d = 1'b1;
          tdata_d  = seed_q;
          tlast_d  = (TX_LAST_IDX == '0);
          idx_d    = '0;
          to_d     = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_SEND: begin
        if (tx_hs) begin
          to_d = '0;
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            idx_d    = '0;
            state_d  = ST_RECV;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tdata_d = tdata_q + W'(1);
            tlast_d = ((idx_q + IDX_W'(1)) == TX_LAST_IDX);
          end
        end else if (to_q == TO_END) begin
          err_timeout_d = 1'b1;
          tvalid_d      = 1'b0;
          tlast_d       = 1'b0;
          state_d       = ST_REPORT;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_RECV: begin
        if (rx_hs) begin
          to_d = '0;
          if ((S_AXIS_TDATA != rx_expect) && (err_count_q != 8'hFF))
            err_count_d = err_count_q + 8'd1;
          if (S_AXIS_TLAST != rx_last_idx)
            err_len_d = 1'b1;
          if (S_AXIS_TLAST || rx_last_idx)
            state_d = ST_REPORT;
          else
            idx_d = idx_q + IDX_W'(1);
        end else if (to_q == TO_END) begin
          err_timeout_d = 1'b1;
          state_d       = ST_REPORT;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Verdict is latched as the run ends so it is visible alongside done.
    if ((state_q != ST_REPORT) && (state_d == ST_REPORT))
      pass_d = !(err_len_d | err_timeout_d | (err_count_d != 8'd0));
  end

  // State register; reset clears everything at once, including TVALID.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q       <= ST_IDLE;
      seed_q        <= '0;
      idx_q         <= '0;
      wait_q        <= '0;
      to_q          <= '0;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      tlast_q       <= 1'b0;
      err_count_q   <= '0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      seed_q        <= seed_d;
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      to_q          <= to_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      tlast_q       <= tlast_d;
      err_count_q   <= err_count_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      pass_q        <= pass_d;
    end
  end

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TSTRB  = '1;
  assign S_AXIS_TREADY = s_tready;

  assign busy        = (state_q == ST_WAIT) | (state_q == ST_SEND) | (state_q == ST_RECV);
  assign done        = (state_q == ST_REPORT);
  assign pass        = pass_q;
  assign err_count   = err_count_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign led         = {busy, err_timeout_q, err_len_q | (err_count_q != 8'd0), pass_q};

endmodule

// File: tb/tb_axis_stream_exerciser.sv
// Testbench for axis_stream_exerciser: acts as the sink for M_AXIS and the
// reply source for S_AXIS, and checks results against a packet-level model.
module tb_axis_stream_exerciser;

  localparam int SC   = 32;
  localparam int TO   = 16;
  localparam int TX   = 8;
  localparam int RX   = 8;
  localparam int NREP = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic        m_tvalid, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tready = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tstrb = '0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        busy, done, pass, err_len, err_timeout;
  logic [7:0]  err_count;
  logic [3:0]  led;

  int checks = 0;
  int failures = 0;

  // Reply packet presented on S_AXIS for the current run.
  logic [31:0] reply_data [NREP];
  logic        reply_last [NREP];

  // Observations from the current run.
  logic [31:0] sent_q[$];
  logic        sent_last_q[$];
  int first_lat, first_hs, last_hs, done_cnt, done_at, ptr;
  int stab_viol, early_tready, recv_viol, recv_cycles, val_cycles, busy_after_done, stall_cycles;
  bit bound_hit;
  logic [31:0] first_tdata;
  logic res_pass, res_el, res_to, res_busy;
  logic [7:0] res_ec;
  logic [3:0] res_led;
  logic post_busy, post_done, post_pass;
  logic [3:0] post_led;

  axis_stream_exerciser #(
    .C_M_AXIS_TDATA_WIDTH(32), .C_S_AXIS_TDATA_WIDTH(32), .C_TX_WORDS(TX),
    .C_RX_WORDS(RX), .C_START_COUNT(SC), .C_TIMEOUT(TO)
  ) dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .start(start), .seed(seed),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb),
    .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
    .S_AXIS_TREADY(s_tready), .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TVALID(s_tvalid),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .err_len(err_len), .err_timeout(err_timeout), .led(led)
  );

  always #5 clk = ~clk;

  // Packet-level reference: which reply words are consumed and what they cost.
  function automatic void model(input logic [31:0] sd, output int n, output int ec, output bit el);
    n = 0; ec = 0; el = 1'b0;
    for (int k = 0; k < NREP; k++) begin
      if (reply_data[k] != sd + 32'(k)) ec = (ec < 255) ? ec + 1 : 255;
      n = k + 1;
      if (reply_last[k] || (k == RX - 1)) begin
        el = (reply_last[k] != (k == RX - 1));
        break;
      end
    end
  endfunction

  // Ideal echo of the sent packet, TLAST at tl_pos, optional corrupted word.
  task automatic fill_reply(input logic [31:0] sd, input int tl_pos, input int bad_idx);
    for (int k = 0; k < NREP; k++) begin
      reply_data[k] = (k == bad_idx) ? 32'hDEADBEEF : sd + 32'(k);
      reply_last[k] = (k == tl_pos);
    end
  endtask

  // One test run: pulse start, act as sink (mode 0 ready, 1 stall word 1,
  // 2 never ready, 3 random) and reply source, record everything observed.
  task automatic run(input logic [31:0] sd, input int mode, input bit rgap,
                     input int extra_at, input logic [31:0] extra_seed);
    bit m_wait, last_pushed, tx_done, s_hs;
    logic prev_tr;
    logic [31:0] hold_data;
    logic hold_last;
    int stall_left, zero_run, i;
    sent_q.delete(); sent_last_q.delete();
    first_lat = -1; first_hs = -1; last_hs = -1; done_cnt = 0; done_at = -1; ptr = 0;
    stab_viol = 0; early_tready = 0; recv_viol = 0; recv_cycles = 0; val_cycles = 0;
    busy_after_done = 0; stall_cycles = 0; bound_hit = 1'b0; first_tdata = '0;
    res_pass = 1'b0; res_el = 1'b0; res_to = 1'b0; res_busy = 1'b0; res_ec = '0; res_led = '0;
    post_busy = 1'b0; post_done = 1'b0; post_pass = 1'b0; post_led = '0;
    m_wait = 1'b0; last_pushed = 1'b0; tx_done = 1'b0; s_hs = 1'b0; prev_tr = 1'b0;
    hold_data = '0; hold_last = 1'b0; stall_left = 3; zero_run = 0;
    @(negedge clk);
    start = 1'b1; seed = sd; m_tready = 1'b0; s_tvalid = 1'b0;
    i = 0;
    forever begin
      @(negedge clk);
      i++;
      start = (i == extra_at);
      if (i == extra_at) seed = extra_seed;
      else if (i == 1) seed = ~sd;
      if (last_pushed) tx_done = 1'b1;
      if (s_hs) ptr++;
      if (m_tvalid) begin
        val_cycles++;
        if (first_lat < 0) begin first_lat = i - 1; first_tdata = m_tdata; end
      end
      if (m_wait && (m_tvalid !== 1'b1 || m_tdata !== hold_data || m_tlast !== hold_last)) stab_viol++;
      if (s_tready && !tx_done) early_tready++;
      if (tx_done && done_cnt == 0 && !done) begin
        recv_cycles++;
`ifdef AXIS_EXERCISER_BACKPRESSURE_EN
        if (recv_cycles > 1 && s_tready === prev_tr) recv_viol++;
`else
        if (s_tready !== 1'b1) recv_viol++;
`endif
        prev_tr = s_tready;
      end
      if (done_cnt > 0 && busy) busy_after_done++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at = i; res_pass = pass; res_el = err_len; res_to = err_timeout;
          res_ec = err_count; res_led = led; res_busy = busy;
        end
      end
      if (done_at > 0 && i == done_at + 1) begin
        post_busy = busy; post_done = done; post_pass = pass; post_led = led;
      end
      if (done_at > 0 && i >= done_at + 4) break;
      if (i > 600) begin bound_hit = 1'b1; break; end
      case (mode)
        0: m_tready = 1'b1;
        1: begin
          if (m_tvalid && sent_q.size() == 1 && stall_left > 0) begin
            m_tready = 1'b0; stall_left--; stall_cycles++;
          end else m_tready = 1'b1;
        end
        2: m_tready = 1'b0;
        default: begin
          m_tready = (zero_run >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
          zero_run = m_tready ? 0 : zero_run + 1;
        end
      endcase
      last_pushed = 1'b0;
      m_wait = m_tvalid && !m_tready;
      hold_data = m_tdata; hold_last = m_tlast;
      if (m_tvalid && m_tready) begin
        sent_q.push_back(m_tdata); sent_last_q.push_back(m_tlast);
        if (first_hs < 0) first_hs = i;
        last_hs = i;
        if (m_tlast) last_pushed = 1'b1;
      end
      if (ptr >= NREP) begin
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
      end else begin
        if (!s_tvalid || s_hs) s_tvalid = (rgap && tx_done) ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_tdata = reply_data[ptr]; s_tlast = reply_last[ptr];
      end
      s_hs = s_tvalid && s_tready;
    end
    start = 1'b0; m_tready = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    $display("run seed=%08h sent=%0d replies=%0d lat=%0d done_at=%0d pass=%0b err_count=%0d err_len=%0b err_timeout=%0b",
             sd, sent_q.size(), ptr, first_lat, done_at, res_pass, res_ec, res_el, res_to);
  endtask

  task automatic test_reset();
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    checks++; if (m_tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    checks++; if (m_tstrb !== 4'hF) begin failures++; $display("FAIL reset_tstrb: got %h want f", m_tstrb); end
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL reset_s_tready: got %b want 0", s_tready); end
    checks++; if ({busy, done, pass, err_len, err_timeout} !== 5'b0) begin failures++; $display("FAIL reset_flags: got %b want 00000", {busy, done, pass, err_len, err_timeout}); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    checks++; if (led !== 4'b0) begin failures++; $display("FAIL reset_led: got %b want 0000", led); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin failures++; $display("FAIL idle_no_start: got busy=%b tvalid=%b want 0 0", busy, m_tvalid); end
  endtask

  task automatic test_ideal_loopback();
    int n, ec; bit el;
    fill_reply(32'h10, RX - 1, -1);
    run(32'h10, 0, 1'b0, -1, 32'h0);
    model(32'h10, n, ec, el);
    checks++; if (bound_hit) begin failures++; $display("FAIL ideal_bound: got no done want done"); end
    checks++; if (first_lat !== SC + 1) begin failures++; $display("FAIL ideal_latency: got %0d want %0d", first_lat, SC + 1); end
    checks++; if (sent_q.size() !== TX) begin failures++; $display("FAIL ideal_sent_len: got %0d want %0d", sent_q.size(), TX); end
    for (int k = 0; k < sent_q.size(); k++) begin
      checks++; if (sent_q[k] !== 32'h10 + 32'(k) || sent_last_q[k] !== (k == TX - 1))
        begin failures++; $display("FAIL ideal_word%0d: got %h/%b want %h/%b", k, sent_q[k], sent_last_q[k], 32'h10 + 32'(k), k == TX - 1); end
    end
    checks++; if (last_hs - first_hs !== TX - 1) begin failures++; $display("FAIL ideal_beats: got span %0d want %0d", last_hs - first_hs, TX - 1); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ideal_done_pulses: got %0d want 1", done_cnt); end
    checks++; if (ptr !== n) begin failures++; $display("FAIL ideal_consumed: got %0d want %0d", ptr, n); end
    checks++; if (res_pass !== 1'b1 || res_ec !== 8'(ec) || res_el !== el) begin failures++; $display("FAIL ideal_status: got pass=%b ec=%0d el=%b want 1 %0d %b", res_pass, res_ec, res_el, ec, el); end
    checks++; if (res_led !== 4'b0001) begin failures++; $display("FAIL ideal_led: got %b want 0001", res_led); end
    checks++; if (res_busy !== 1'b0) begin failures++; $display("FAIL ideal_busy_at_done: got %b want 0", res_busy); end
    checks++; if (early_tready !== 0) begin failures++; $display("FAIL ideal_tready_outside_recv: got %0d cycles want 0", early_tready); end
    checks++; if (recv_viol !== 0 || recv_cycles < 1) begin failures++; $display("FAIL ideal_recv_tready: got %0d bad of %0d want 0", recv_viol, recv_cycles); end
    checks++; if (post_pass !== 1'b1 || post_led !== 4'b0001) begin failures++; $display("FAIL ideal_hold: got pass=%b led=%b want 1 0001", post_pass, post_led); end
  endtask

  task automatic test_corrupt_word();
    fill_reply(32'h10, RX - 1, 3);
    run(32'h10, 0, 1'b0, -1, 32'h0);
    checks++; if (res_ec !== 8'd1) begin failures++; $display("FAIL corrupt_err_count: got %0d want 1", res_ec); end
    checks++; if (res_pass !== 1'b0 || res_el !== 1'b0 || res_to !== 1'b0) begin failures++; $display("FAIL corrupt_flags: got pass=%b el=%b to=%b want 0 0 0", res_pass, res_el, res_to); end
    checks++; if (res_led !== 4'b0010) begin failures++; $display("FAIL corrupt_led: got %b want 0010", res_led); end
  endtask

  task automatic test_early_tlast();
    int n, ec; bit el;
    fill_reply(32'h10, 4, -1);
    run(32'h10, 0, 1'b0, -1, 32'h0);
    model(32'h10, n, ec, el);
    checks++; if (res_el !== 1'b1 || el !== 1'b1) begin failures++; $display("FAIL early_err_len: got %b want 1", res_el); end
    checks++; if (res_pass !== 1'b0 || res_ec !== 8'd0) begin failures++; $display("FAIL early_status: got pass=%b ec=%0d want 0 0", res_pass, res_ec); end
    checks++; if (ptr !== n) begin failures++; $display("FAIL early_consumed: got %0d want %0d", ptr, n); end
    checks++; if (post_busy !== 1'b0 || post_done !== 1'b0) begin failures++; $display("FAIL early_idle_after_done: got busy=%b done=%b want 0 0", post_busy, post_done); end
    checks++; if (post_led !== 4'b0010) begin failures++; $display("FAIL early_led_hold: got %b want 0010", post_led); end
  endtask

  task automatic test_wrap_stall();
    logic [31:0] sd;
    sd = 32'hFFFFFFFE;
    fill_reply(sd, RX - 1, -1);
    run(sd, 1, 1'b0, -1, 32'h0);
    checks++; if (stall_cycles !== 3) begin failures++; $display("FAIL wrap_stall_applied: got %0d want 3", stall_cycles); end
    checks++; if (stab_viol !== 0) begin failures++; $display("FAIL wrap_stable: got %0d changes want 0", stab_viol); end
    checks++; if (sent_q.size() !== TX) begin failures++; $display("FAIL wrap_sent_len: got %0d want %0d", sent_q.size(), TX); end
    for (int k = 0; k < sent_q.size(); k++) begin
      checks++; if (sent_q[k] !== sd + 32'(k)) begin failures++; $display("FAIL wrap_word%0d: got %h want %h", k, sent_q[k], sd + 32'(k)); end
    end
    checks++; if (res_pass !== 1'b1) begin failures++; $display("FAIL wrap_pass: got %b want 1", res_pass); end
  endtask

  task automatic test_timeout_busy_start();
    logic [31:0] sd;
    sd = 32'hC0DE0001;
    fill_reply(sd, RX - 1, -1);
    run(sd, 2, 1'b0, 20, 32'h12345678);
    checks++; if (res_to !== 1'b1) begin failures++; $display("FAIL timeout_flag: got %b want 1", res_to); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL timeout_done: got %0d pulses want 1", done_cnt); end
    checks++; if (res_pass !== 1'b0 || res_led !== 4'b0100) begin failures++; $display("FAIL timeout_status: got pass=%b led=%b want 0 0100", res_pass, res_led); end
    checks++; if (val_cycles < TO || val_cycles > TO + 1) begin failures++; $display("FAIL timeout_window: got %0d valid cycles want %0d..%0d", val_cycles, TO, TO + 1); end
    checks++; if (first_lat !== SC + 1 || first_tdata !== sd) begin failures++; $display("FAIL busy_start_ignored: got lat=%0d data=%h want %0d %h", first_lat, first_tdata, SC + 1, sd); end
    checks++; if (busy_after_done !== 0) begin failures++; $display("FAIL busy_start_queued: got %0d busy cycles want 0", busy_after_done); end
    checks++; if (early_tready !== 0 || ptr !== 0) begin failures++; $display("FAIL timeout_no_accept: got tready=%0d replies=%0d want 0 0", early_tready, ptr); end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); start = 1'b1; seed = 32'hA5A5A5A5; m_tready = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (SC + 4) @(negedge clk);
    checks++; if (m_tvalid !== 1'b1) begin failures++; $display("FAIL midreset_in_send: got tvalid=%b want 1", m_tvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tlast !== 1'b0) begin failures++; $display("FAIL midreset_m_axis: got %b %h %b want 0 0 0", m_tvalid, m_tdata, m_tlast); end
    checks++; if (s_tready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midreset_ctrl: got tready=%b busy=%b done=%b want 0 0 0", s_tready, busy, done); end
    checks++; if ({pass, err_len, err_timeout} !== 3'b0 || err_count !== 8'd0 || led !== 4'b0) begin failures++; $display("FAIL midreset_status: got %b %0d %b want 000 0 0000", {pass, err_len, err_timeout}, err_count, led); end
    @(negedge clk); start = 1'b1; seed = 32'h1;
    @(negedge clk); start = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_during_reset: got busy=%b want 0", busy); end
  endtask

  task automatic test_random();
    logic [31:0] sd;
    int n, ec, tl, bad;
    bit el, exp_pass;
    for (int r = 0; r < 8; r++) begin
      sd = $urandom;
      tl = $urandom_range(0, NREP - 1);
      for (int k = 0; k < NREP; k++) begin
        reply_data[k] = ($urandom_range(0, 3) == 0) ? $urandom : sd + 32'(k);
        reply_last[k] = (k == tl);
      end
      run(sd, 3, 1'b1, -1, 32'h0);
      model(sd, n, ec, el);
      exp_pass = !(el || ec != 0);
      bad = 0;
      for (int k = 0; k < sent_q.size(); k++) if (sent_q[k] !== sd + 32'(k) || sent_last_q[k] !== (k == TX - 1)) bad++;
      checks++; if (sent_q.size() !== TX || bad !== 0) begin failures++; $display("FAIL rand%0d_tx: got %0d words %0d bad want %0d 0", r, sent_q.size(), bad, TX); end
      checks++; if (stab_viol !== 0) begin failures++; $display("FAIL rand%0d_stable: got %0d want 0", r, stab_viol); end
      checks++; if (ptr !== n) begin failures++; $display("FAIL rand%0d_consumed: got %0d want %0d", r, ptr, n); end
      checks++; if (res_ec !== 8'(ec) || res_el !== el || res_to !== 1'b0) begin failures++; $display("FAIL rand%0d_errors: got ec=%0d el=%b to=%b want %0d %b 0", r, res_ec, res_el, res_to, ec, el); end
      checks++; if (res_pass !== exp_pass || res_led !== {2'b00, el || ec != 0, exp_pass}) begin failures++; $display("FAIL rand%0d_verdict: got pass=%b led=%b want %b %b", r, res_pass, res_led, exp_pass, {2'b00, el || ec != 0, exp_pass}); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rand%0d_done: got %0d want 1", r, done_cnt); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_ideal_loopback();
    test_corrupt_word();
    test_early_tlast();
    test_wrap_stall();
    test_timeout_busy_start();
    test_reset_mid_run();
    test_ideal_loopback();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
